// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package lsu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } lsu_state_e;

  localparam logic       MEM_WORD = 1'b0;
  localparam logic       MEM_BYTE = 1'b1;
  localparam logic [3:0] STRB_ALL = 4'hF;

  // Word accesses must be 4-byte aligned; byte accesses never misalign.
  function automatic logic is_misaligned(input logic mem_type, input logic [1:0] off);
    return (mem_type == MEM_WORD) && (off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/replicated data and LBU-style load extraction.
module mem_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic        mem_type_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_rdata_i,
  output logic [3:0]  st_strb_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  always_comb begin
    st_strb_o = STRB_ALL;
    st_data_o = st_data_i;
    ld_data_o = ld_rdata_i;
    if (mem_type_i == MEM_BYTE) begin
      st_strb_o = 4'b0001 << off_i;
      st_data_o = {4{st_data_i[7:0]}};
      ld_data_o = {24'b0, ld_rdata_i[{off_i, 3'b000} +: 8]};
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: drives the req/ready data bus, stalls while an access is
// outstanding, and owns the MEM/WB pipeline register.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              ResultSrcM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [4:0]        RdM,
  input  logic              MemTypeM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              StallM,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [ADDR_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [4:0]        RdW,
  output logic              MisalignW
);

  lsu_state_e state_q, state_d;
  logic       access, is_load;
  logic       bus_load, done, wb_bubble;
  logic [1:0] off_q;
  logic       type_q, load_q;

  logic [1:0]        al_off;
  logic              al_type;
  logic [3:0]        al_strb;
  logic [DATA_W-1:0] al_wdata, al_rdata;

  // Store with ResultSrcM also set is treated as a store.
  assign access  = ResultSrcM | MemWriteM;
  assign is_load = ResultSrcM & ~MemWriteM;

  // Aligner sees live M fields while issuing, latched ones while waiting.
  assign al_off  = (state_q == IDLE) ? ALUResultM[1:0] : off_q;
  assign al_type = (state_q == IDLE) ? MemTypeM : type_q;

  mem_lane_align u_align (
    .off_i      (al_off),
    .mem_type_i (al_type),
    .st_data_i  (WriteDataM),
    .ld_rdata_i (mem_rdata),
    .st_strb_o  (al_strb),
    .st_data_o  (al_wdata),
    .ld_data_o  (al_rdata)
  );

  always_comb begin
    state_d   = state_q;
    StallM    = 1'b0;
    bus_load  = 1'b0;
    done      = 1'b0;
    wb_bubble = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          StallM    = 1'b1;
          bus_load  = 1'b1;
          wb_bubble = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          StallM    = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) StallM = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      off_q      <= '0;
      type_q     <= MEM_WORD;
      load_q     <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
      MisalignW  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus_load) begin
        mem_req   <= 1'b1;
        mem_we    <= MemWriteM;
        mem_addr  <= {ALUResultM[ADDR_W-1:2], 2'b00};
        mem_wdata <= MemWriteM ? al_wdata : '0;
        mem_wstrb <= MemWriteM ? al_strb : 4'h0;
        off_q     <= ALUResultM[1:0];
        type_q    <= MemTypeM;
        load_q    <= is_load;
      end else if (done) begin
        mem_req <= 1'b0;
      end
      if (wb_bubble) begin
        RegWriteW  <= 1'b0;
        ResultSrcW <= 1'b0;
        ALUResultW <= '0;
        ReadDataW  <= '0;
        RdW        <= '0;
        MisalignW  <= 1'b0;
      end else begin
        RegWriteW  <= RegWriteM;
        ResultSrcW <= ResultSrcM;
        ALUResultW <= ALUResultM;
        ReadDataW  <= (done && load_q) ? al_rdata : '0;
        RdW        <= RdM;
        MisalignW  <= done && is_misaligned(type_q, off_q);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a transaction-level model and per-cycle compare.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, ResultSrcM, MemWriteM, MemTypeM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  RdM;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        StallM, RegWriteW, ResultSrcW, MisalignW;
  logic [31:0] ALUResultW, ReadDataW;
  logic [4:0]  RdW;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .MemTypeM(MemTypeM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW), .MisalignW(MisalignW)
  );

  typedef struct packed {
    logic        regw;
    logic        rsrc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        mis;
  } wb_t;

  wb_t         exp_wb;
  logic        exp_stall, exp_req, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  bit          chk_on = 0, chk_stall = 1;
  int          n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // What the writeback register must hold after an instruction completes.
  function automatic wb_t model_wb(input logic regw, rsrc, we, mt, input logic [31:0] alu,
                                   input logic [4:0] rd, input logic [31:0] rdata);
    wb_t w;
    int  off = int'(alu % 4);
    w.regw  = regw;
    w.rsrc  = rsrc;
    w.alu   = alu;
    w.rd    = rd;
    w.rdata = 32'h0;
    if (rsrc && !we) w.rdata = mt ? ((rdata >> (8 * off)) & 32'hFF) : rdata;
    w.mis   = (mt == 1'b0) && (off != 0);
    return w;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      if (chk_stall) check("StallM", {31'b0, StallM}, {31'b0, exp_stall});
      check("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
      if (exp_req) begin
        check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
        check("mem_addr", mem_addr, exp_addr);
        if (exp_we) begin
          check("mem_wdata", mem_wdata, exp_wdata);
          check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, exp_wstrb});
        end
      end
      check("RegWriteW", {31'b0, RegWriteW}, {31'b0, exp_wb.regw});
      check("ResultSrcW", {31'b0, ResultSrcW}, {31'b0, exp_wb.rsrc});
      check("ALUResultW", ALUResultW, exp_wb.alu);
      check("ReadDataW", ReadDataW, exp_wb.rdata);
      check("RdW", {27'b0, RdW}, {27'b0, exp_wb.rd});
      check("MisalignW", {31'b0, MisalignW}, {31'b0, exp_wb.mis});
    end
  end

  task automatic drive_m(input logic regw, rsrc, we, mt, input logic [31:0] alu, wd,
                         input logic [4:0] rd);
    RegWriteM = regw; ResultSrcM = rsrc; MemWriteM = we; MemTypeM = mt;
    ALUResultM = alu; WriteDataM = wd; RdM = rd;
  endtask

  // Runs one instruction from issue to writeback; called just after a rising edge.
  task automatic run_op(input logic regw, rsrc, we, mt, input logic [31:0] alu, wd,
                        input logic [4:0] rd, input int waits, input logic [31:0] rdata);
    int off = int'(alu % 4);
    drive_m(regw, rsrc, we, mt, alu, wd, rd);
    mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    if (!(rsrc || we)) begin
      exp_stall = 1'b0; exp_req = 1'b0;
      @(posedge clk); #1;
      exp_wb = model_wb(regw, rsrc, we, mt, alu, rd, 32'h0);
      return;
    end
    exp_stall = 1'b1; exp_req = 1'b0;
    @(posedge clk); #1;
    exp_wb    = '0;
    exp_req   = 1'b1;
    exp_we    = we;
    exp_addr  = alu - (alu % 4);
    exp_wdata = mt ? wd[7:0] * 32'h0101_0101 : wd;
    exp_wstrb = mt ? 4'(1 << off) : 4'hF;
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
    end
    mem_ready = 1'b1; mem_rdata = rdata; exp_stall = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    exp_req = 1'b0;
    exp_wb  = model_wb(regw, rsrc, we, mt, alu, rd, rdata);
  endtask

  // First half of an idle cycle; caller may pin literals before idle_end.
  task automatic idle_begin();
    drive_m(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    mem_ready = 1'b0; exp_stall = 1'b0; exp_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_end();
    @(posedge clk); #1;
    exp_wb = '0;
  endtask

  initial begin
    rst = 1'b1;
    drive_m(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    exp_wb = '0; exp_stall = 1'b0; exp_req = 1'b0;
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
    @(posedge clk); #1;
    chk_on = 1;
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU op: no stall, fields pass straight through.
    run_op(1, 0, 0, 0, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
    idle_begin();
    check("lit ALUResultW", ALUResultW, 32'h0000_1234);
    check("lit RdW", {27'b0, RdW}, 32'd5);
    idle_end();

    run_op(0, 0, 1, 0, 32'h100, 32'hDEAD_BEEF, 5'd0, 0, 32'h0);
    run_op(0, 0, 1, 1, 32'h203, 32'h0000_00A5, 5'd0, 1, 32'h0);
    run_op(1, 1, 0, 1, 32'h302, 32'h0, 5'd7, 3, 32'h11C3_5577);
    idle_begin();
    check("lit ReadDataW lane2", ReadDataW, 32'h0000_00C3);
    check("lit RegWriteW load", {31'b0, RegWriteW}, 32'd1);
    idle_end();

    run_op(1, 1, 0, 0, 32'h106, 32'h0, 5'd9, 0, 32'hCAFE_F00D);
    idle_begin();
    check("lit MisalignW", {31'b0, MisalignW}, 32'd1);
    check("lit ReadDataW word", ReadDataW, 32'hCAFE_F00D);
    idle_end();

    // Both ResultSrcM and MemWriteM set: behaves as a store.
    run_op(0, 1, 1, 1, 32'h001, 32'h1234_563C, 5'd0, 2, 32'h5555_5555);
    // Back-to-back byte loads on lanes 0 and 3, then a misaligned word store.
    run_op(1, 1, 0, 1, 32'h400, 32'h0, 5'd1, 0, 32'h8899_AABB);
    run_op(1, 1, 0, 1, 32'h407, 32'h0, 5'd2, 1, 32'h8899_AABB);
    run_op(0, 0, 1, 0, 32'h502, 32'h0BAD_F00D, 5'd0, 0, 32'h0);
    run_op(1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 5'd31, 0, 32'h0);
    idle_begin();
    idle_end();

    // Reset in the middle of a waiting load abandons it.
    drive_m(1, 1, 0, 0, 32'h600, 32'h0, 5'd3);
    mem_ready = 1'b0; exp_stall = 1'b1; exp_req = 1'b0;
    @(posedge clk); #1;
    exp_wb = '0; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h600;
    @(posedge clk); #1;
    rst = 1'b1; chk_stall = 0;
    @(posedge clk); #1;
    rst = 1'b0; chk_stall = 1;
    drive_m(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    exp_req = 1'b0; exp_stall = 1'b0; exp_wb = '0;
    @(negedge clk);
    check("lit rst mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    // A stray ready pulse afterwards must not produce a writeback.
    mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("lit stray ready ReadDataW", ReadDataW, 32'h0);
    @(posedge clk); #1;

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
